// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak message packer: word geometry,
// FSM state encoding and the byte-placement helper.
package keccak_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BNUM_W         = 2;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    PACK  = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4,
    WAIT  = 3'd5
  } state_t;

  // Big-endian placement: byte index 0 lands in the top byte of the word.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] w,
                                                   input logic [7:0]        b,
                                                   input logic [CNT_W-1:0]  idx);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (idx == CNT_W'(i)) r[WORD_W-1-8*i -: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/keccak_word_assembler.sv
// Byte-to-word assembler: tracks the byte index and the partially built word,
// flagging the byte that completes a word or ends the message.
module keccak_word_assembler
  import keccak_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        data,
  input  logic              last,
  output logic [WORD_W-1:0] word,
  output logic              word_done,
  output logic [CNT_W-1:0]  last_cnt
);
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] asm_q;

  // word already includes the byte being accepted this cycle
  assign word      = place_byte(asm_q, data, cnt_q);
  assign word_done = accept && (last || cnt_q == CNT_W'(BYTES_PER_WORD-1));
  assign last_cnt  = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      asm_q <= word_done ? '0 : word;
    end
  end
endmodule

// File: rtl/keccak_msg_packer.sv
// Byte-stream to keccak-core word feeder with per-message core reset, pad word
// and digest wait. Optional msg_len counter enabled by KECCAK_MSG_PACKER_LEN_EN.
module keccak_msg_packer
  import keccak_pkg::*;
#(
  parameter bit WAIT_DIGEST = 1'b1
`ifdef KECCAK_MSG_PACKER_LEN_EN
  , parameter int LEN_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              core_reset,
  output logic [WORD_W-1:0] k_in,
  output logic              k_in_ready,
  output logic              k_is_last,
  output logic [BNUM_W-1:0] k_byte_num,
  input  logic              k_buffer_full,
  input  logic              k_out_ready,
  output logic              busy,
  output logic              msg_done
`ifdef KECCAK_MSG_PACKER_LEN_EN
  , output logic [LEN_W-1:0] msg_len
`endif
);
  state_t            state_q, state_d;
  logic              slot_free, xfer, accept, msg_done_d;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic [CNT_W-1:0]  last_cnt;
  logic              short_last;

  assign slot_free  = !k_in_ready || !k_buffer_full;
  assign xfer       = k_in_ready && !k_buffer_full;
  assign accept     = s_valid && s_ready;
  assign short_last = s_last && (last_cnt != CNT_W'(BYTES_PER_WORD-1));
  assign busy       = (state_q != IDLE);

  keccak_word_assembler u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (state_q == CLR),
    .accept    (accept),
    .data      (s_data),
    .last      (s_last),
    .word      (word),
    .word_done (word_done),
    .last_cnt  (last_cnt)
  );

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    core_reset = 1'b0;
    msg_done_d = 1'b0;
    case (state_q)
      IDLE:  if (s_valid) state_d = CLR;
      CLR: begin
        core_reset = 1'b1;
        state_d    = PACK;
      end
      PACK: begin
        s_ready = slot_free;
        // a last byte that fills a word still owes the core a zero pad word
        if (accept && s_last) state_d = short_last ? DRAIN : FLUSH;
      end
      FLUSH: if (slot_free) state_d = DRAIN;
      DRAIN: begin
        if (xfer) begin
          if (WAIT_DIGEST) state_d = WAIT;
          else begin
            state_d    = IDLE;
            msg_done_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (k_out_ready) begin
          state_d    = IDLE;
          msg_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      msg_done   <= 1'b0;
      k_in       <= '0;
      k_in_ready <= 1'b0;
      k_is_last  <= 1'b0;
      k_byte_num <= '0;
    end else begin
      state_q  <= state_d;
      msg_done <= msg_done_d;
      if (word_done) begin
        k_in       <= word;
        k_in_ready <= 1'b1;
        k_is_last  <= short_last;
        k_byte_num <= short_last ? BNUM_W'(last_cnt + 1'b1) : '0;
      end else if (state_q == FLUSH && slot_free) begin
        k_in       <= '0;
        k_in_ready <= 1'b1;
        k_is_last  <= 1'b1;
        k_byte_num <= '0;
      end else if (xfer) begin
        k_in_ready <= 1'b0;
        k_is_last  <= 1'b0;
        k_byte_num <= '0;
      end
    end
  end

`ifdef KECCAK_MSG_PACKER_LEN_EN
  // saturating byte count; only PACK accepts bytes, so it freezes afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      msg_len <= '0;
    else if (state_q == CLR)           msg_len <= '0;
    else if (accept && msg_len != '1)  msg_len <= msg_len + 1'b1;
  end
`endif
endmodule

// File: tb/tb_keccak_msg_packer.sv
// Directed bench for keccak_msg_packer: byte messages in, word transfers
// recorded and compared against hand-derived words.
module tb_keccak_msg_packer;
  import keccak_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              core_reset;
  logic [WORD_W-1:0] k_in;
  logic              k_in_ready;
  logic              k_is_last;
  logic [BNUM_W-1:0] k_byte_num;
  logic              k_buffer_full = 1'b0;
  logic              k_out_ready = 1'b0;
  logic              busy;
  logic              msg_done;
`ifdef KECCAK_MSG_PACKER_LEN_EN
  logic [15:0]       msg_len;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cr_cnt   = 0;
  int md_cnt   = 0;
  logic [31:0] xw[$];
  logic        xl[$];
  logic [1:0]  xb[$];

  always #5 clk = ~clk;

  keccak_msg_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .core_reset    (core_reset),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .k_out_ready   (k_out_ready),
    .busy          (busy),
    .msg_done      (msg_done)
`ifdef KECCAK_MSG_PACKER_LEN_EN
    , .msg_len     (msg_len)
`endif
  );

  // a transfer seen at a negedge completes at the following posedge
  always @(negedge clk) begin
    if (reset_n && k_in_ready && !k_buffer_full) begin
      xw.push_back(k_in);
      xl.push_back(k_is_last);
      xb.push_back(k_byte_num);
    end
    if (core_reset) cr_cnt++;
    if (msg_done)   md_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    xw.delete(); xl.delete(); xb.delete();
    cr_cnt = 0; md_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    @(negedge clk);
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_str(input string s, input int n);
    for (int i = 0; i < n; i++) send_byte(s[i], (i == s.len()-1));
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int t;
    t = 0;
    while (xw.size() < n && t < 300) begin @(negedge clk); t++; end
    check(tag, 32'(xw.size()), 32'(n));
  endtask

  task automatic check_xfer(input int i, input logic [31:0] w, input logic l, input logic [1:0] b);
    check($sformatf("word%0d", i), xw[i], w);
    check($sformatf("last%0d", i), 32'(xl[i]), 32'(l));
    check($sformatf("bnum%0d", i), 32'(xb[i]), 32'(b));
  endtask

  task automatic pulse_out_ready();
    @(posedge clk); #1 k_out_ready = 1'b1;
    @(posedge clk); #1 k_out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst_k_in", k_in, 32'h0);
    check("rst_outs", {28'd0, k_in_ready, k_is_last, s_ready, core_reset},  32'h0);
    check("rst_misc", {28'd0, busy, msg_done, k_byte_num}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 13-byte message ending one byte into a word
    clear_log();
    send_str("Hello, world!", 13);
    wait_xfers(4, "hello_nxfer");
    check_xfer(0, 32'h48656c6c, 1'b0, 2'd0);
    check_xfer(1, 32'h6f2c2077, 1'b0, 2'd0);
    check_xfer(2, 32'h6f726c64, 1'b0, 2'd0);
    check_xfer(3, 32'h21000000, 1'b1, 2'd1);
    @(negedge clk); @(negedge clk);
    check("hello_core_reset", 32'(cr_cnt), 32'd1);
    check("hello_wait_busy", 32'(busy), 32'd1);
    check("hello_no_done_yet", 32'(md_cnt), 32'd0);
    pulse_out_ready();
    check("hello_msg_done", 32'(md_cnt), 32'd1);
    check("hello_idle", 32'(busy), 32'd0);

    // 20-byte message: word-aligned, pad word follows
    clear_log();
    send_str("The quick brown fox.", 20);
    wait_xfers(6, "fox_nxfer");
    repeat (5) @(negedge clk);
    check("fox_exact6", 32'(xw.size()), 32'd6);
    check_xfer(0, 32'h54686520, 1'b0, 2'd0);
    check_xfer(1, 32'h71756963, 1'b0, 2'd0);
    check_xfer(2, 32'h6b206272, 1'b0, 2'd0);
    check_xfer(3, 32'h6f776e20, 1'b0, 2'd0);
    check_xfer(4, 32'h666f782e, 1'b0, 2'd0);
    check_xfer(5, 32'h00000000, 1'b1, 2'd0);
    pulse_out_ready();

    // stall with "1234" pending while '5' is offered
    clear_log();
    k_buffer_full = 1'b1;
    send_str("12345", 4);
    s_data = "5"; s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_k_in%0d", i), k_in, 32'h31323334);
      check($sformatf("stall_sready%0d", i), {31'd0, s_ready}, 32'd0);
      check($sformatf("stall_inrdy%0d", i), {31'd0, k_in_ready}, 32'd1);
    end
    check("stall_no_xfer", 32'(xw.size()), 32'd0);
    @(posedge clk); #1 k_buffer_full = 1'b0;
    send_byte("5", 1'b1);
    wait_xfers(2, "stall_nxfer");
    repeat (4) @(negedge clk);
    check("stall_exact2", 32'(xw.size()), 32'd2);
    check_xfer(0, 32'h31323334, 1'b0, 2'd0);
    check_xfer(1, 32'h35000000, 1'b1, 2'd1);

    // second message offered while waiting for the digest
    clear_log();
    s_data = "A"; s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wait_sready%0d", i), {31'd0, s_ready}, 32'd0);
    end
    check("wait_no_core_reset", 32'(cr_cnt), 32'd0);
    @(posedge clk); #1 k_out_ready = 1'b1;
    @(posedge clk); #1 k_out_ready = 1'b0;
    send_byte("A", 1'b0);
    check("wait_done_before_byte", 32'(md_cnt), 32'd1);
    check("wait_reset_before_byte", 32'(cr_cnt), 32'd1);
    send_byte("B", 1'b0);
    send_byte("C", 1'b1);
    wait_xfers(1, "abc_nxfer");
    check_xfer(0, 32'h41424300, 1'b1, 2'd3);
    pulse_out_ready();

    // asynchronous reset mid-message
    clear_log();
    send_str("password123", 6);
    reset_n = 1'b0;
    #1;
    check("arst_k_in", k_in, 32'h0);
    check("arst_outs", {27'd0, k_in_ready, k_is_last, s_ready, busy, msg_done}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    clear_log();
    send_str("XYZW1", 5);
    wait_xfers(2, "clean_nxfer");
    check_xfer(0, 32'h58595a57, 1'b0, 2'd0);
    check_xfer(1, 32'h31000000, 1'b1, 2'd1);
    check("clean_core_reset", 32'(cr_cnt), 32'd1);
    pulse_out_ready();

    // ten digits: final word carries two bytes
    clear_log();
    send_str("1234567890", 10);
    wait_xfers(3, "digits_nxfer");
    check_xfer(0, 32'h31323334, 1'b0, 2'd0);
    check_xfer(1, 32'h35363738, 1'b0, 2'd0);
    check_xfer(2, 32'h39300000, 1'b1, 2'd2);
    @(negedge clk); @(negedge clk);
`ifdef KECCAK_MSG_PACKER_LEN_EN
    check("msg_len", 32'(msg_len), 32'd10);
`endif
    check("digits_k_in_ready_low", {31'd0, k_in_ready}, 32'd0);
    check("digits_is_last_clr", {31'd0, k_is_last}, 32'd0);
    pulse_out_ready();
    check("digits_done", 32'(md_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
